audio_ft2232_stream: RTL and testbench



---
 rtl/audio_pkg.sv | 19 +
 rtl/audio_ft2232_stream_if.sv | 40 ++++
 rtl/audio_ft2232_stream.sv | 125 ++++++++++++
 tb/tb_audio_ft2232_stream.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared constants and state type for the FT2232 audio streamer
package audio_pkg;

  localparam int SAMPLE_BYTES_DEFAULT = 3;

  localparam logic [7:0] CMD_START    = 8'h01;
  localparam logic [7:0] CMD_STOP     = 8'h02;
  localparam logic [7:0] CMD_RATE_48K = 8'h10;
  localparam logic [7:0] CMD_RATE_44K = 8'h11;

  typedef enum logic [2:0] {
    IDLE,
    RD_OE,
    RD,
    TURN,
    WR
  } state_t;

endpackage

// File: rtl/audio_ft2232_stream_if.sv
// rtl/audio_ft2232_stream_if.sv - sample stream and FT2232 245-FIFO pin bundle
interface audio_ft2232_stream_if
  import audio_pkg::*;
#(
  parameter int SAMPLE_BYTES = SAMPLE_BYTES_DEFAULT
);

  logic                      sample_valid_i;
  logic [8*SAMPLE_BYTES-1:0] sample_left_i;
  logic [8*SAMPLE_BYTES-1:0] sample_right_i;
  logic                      sample_ready_o;
  logic                      fifo_txe_n_i;
  logic                      fifo_rxf_n_i;
  logic [7:0]                fifo_data_i;
  logic [7:0]                fifo_data_o;
  logic                      fifo_data_oe_o;
  logic                      fifo_oe_n_o;
  logic                      fifo_rd_n_o;
  logic                      fifo_wr_n_o;
  logic                      fifo_siwu_o;
  logic                      ft2232_reset_n_o;
  logic                      streaming_o;
  logic                      rate_sel_o;
  logic                      led_user_o;

  modport slave (
    input  sample_valid_i, sample_left_i, sample_right_i,
    input  fifo_txe_n_i, fifo_rxf_n_i, fifo_data_i,
    output sample_ready_o, fifo_data_o, fifo_data_oe_o, fifo_oe_n_o, fifo_rd_n_o,
    output fifo_wr_n_o, fifo_siwu_o, ft2232_reset_n_o, streaming_o, rate_sel_o, led_user_o
  );

  modport master (
    output sample_valid_i, sample_left_i, sample_right_i,
    output fifo_txe_n_i, fifo_rxf_n_i, fifo_data_i,
    input  sample_ready_o, fifo_data_o, fifo_data_oe_o, fifo_oe_n_o, fifo_rd_n_o,
    input  fifo_wr_n_o, fifo_siwu_o, ft2232_reset_n_o, streaming_o, rate_sel_o, led_user_o
  );

endinterface

// File: rtl/audio_ft2232_stream.sv
// rtl/audio_ft2232_stream.sv - stereo PCM frames out, single-byte commands in, over FT2232 245 sync FIFO
module audio_ft2232_stream
  import audio_pkg::*;
#(
  parameter int SAMPLE_BYTES = SAMPLE_BYTES_DEFAULT
) (
  input  logic                 fifo_clk_i,
  input  logic                 reset_n_i,
  audio_ft2232_stream_if.slave bus
);

  localparam int FRAME_BYTES = 2 * SAMPLE_BYTES;
  localparam int FRAME_W     = 8 * FRAME_BYTES;
  localparam int IDX_W       = $clog2(FRAME_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  state_t             state;
  logic [FRAME_W-1:0] frame;
  logic [IDX_W-1:0]   byte_idx;
  logic [7:0]         rx_byte;
  logic               rx_valid;
  logic               handshake;

  assign handshake = bus.sample_valid_i & bus.sample_ready_o;

  always_ff @(posedge fifo_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state                <= IDLE;
      frame                <= '0;
      byte_idx             <= '0;
      rx_byte              <= 8'h00;
      rx_valid             <= 1'b0;
      bus.sample_ready_o   <= 1'b0;
      bus.fifo_data_o      <= 8'h00;
      bus.fifo_data_oe_o   <= 1'b0;
      bus.fifo_oe_n_o      <= 1'b1;
      bus.fifo_rd_n_o      <= 1'b1;
      bus.fifo_wr_n_o      <= 1'b1;
      bus.fifo_siwu_o      <= 1'b1;
      bus.ft2232_reset_n_o <= 1'b0;
      bus.streaming_o      <= 1'b0;
      bus.rate_sel_o       <= 1'b0;
      bus.led_user_o       <= 1'b0;
    end else begin
      bus.ft2232_reset_n_o <= 1'b1;
      bus.fifo_siwu_o      <= 1'b1;
      bus.sample_ready_o   <= 1'b0;
      rx_valid             <= 1'b0;

      // Reads only happen outside WR, so commands always land between frames
      if (rx_valid) begin
        case (rx_byte)
          CMD_START: begin
            bus.streaming_o <= 1'b1;
            bus.led_user_o  <= 1'b1;
          end
          CMD_STOP: begin
            bus.streaming_o <= 1'b0;
            bus.led_user_o  <= 1'b0;
          end
          CMD_RATE_48K: bus.rate_sel_o <= 1'b0;
          CMD_RATE_44K: bus.rate_sel_o <= 1'b1;
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          // A sample already handshaken must not be dropped, even if RXF fell the same edge
          if (handshake && bus.streaming_o) begin
            frame <= {bus.sample_right_i, bus.sample_left_i};
            state <= WR;
          end else if (!bus.fifo_rxf_n_i) begin
            state <= RD_OE;
          end else begin
            bus.sample_ready_o <= 1'b1;
          end
        end
        RD_OE: begin
          bus.fifo_oe_n_o    <= 1'b0;
          bus.fifo_data_oe_o <= 1'b0;
          state              <= RD;
        end
        RD: begin
          if (!bus.fifo_rd_n_o && !bus.fifo_rxf_n_i) begin
            rx_byte  <= bus.fifo_data_i;
            rx_valid <= 1'b1;
          end
          if (bus.fifo_rxf_n_i) begin
            bus.fifo_oe_n_o <= 1'b1;
            bus.fifo_rd_n_o <= 1'b1;
            state           <= TURN;
          end else begin
            bus.fifo_rd_n_o <= 1'b0;
          end
        end
        TURN: begin
          bus.sample_ready_o <= bus.fifo_rxf_n_i;
          state              <= IDLE;
        end
        WR: begin
          if (bus.fifo_wr_n_o) begin
            bus.fifo_data_oe_o <= 1'b1;
            bus.fifo_wr_n_o    <= 1'b0;
            bus.fifo_data_o    <= frame[7:0];
          end else if (!bus.fifo_txe_n_i) begin
            if (byte_idx == LAST_IDX) begin
              bus.fifo_wr_n_o    <= 1'b1;
              bus.fifo_data_oe_o <= 1'b0;
              bus.sample_ready_o <= bus.fifo_rxf_n_i;
              byte_idx           <= '0;
              state              <= IDLE;
            end else begin
              bus.fifo_data_o <= frame[15:8];
              frame           <= frame >> 8;
              byte_idx        <= byte_idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_ft2232_stream.sv
// tb/tb_audio_ft2232_stream.sv - directed self-checking bench for audio_ft2232_stream
module tb_audio_ft2232_stream;
  import audio_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   bus_viol = 0;
  logic prev_data_oe = 1'b0;
  logic prev_oe_n = 1'b1;

  audio_ft2232_stream_if #(.SAMPLE_BYTES(3)) bus ();

  audio_ft2232_stream #(.SAMPLE_BYTES(3)) dut (
    .fifo_clk_i(clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Bus contention and turnaround-gap monitor
  always @(negedge clk) begin
    if (bus.fifo_data_oe_o && !bus.fifo_oe_n_o) bus_viol++;
    if ((bus.fifo_data_oe_o && !prev_oe_n) || (!bus.fifo_oe_n_o && prev_data_oe)) bus_viol++;
    prev_data_oe = bus.fifo_data_oe_o;
    prev_oe_n    = bus.fifo_oe_n_o;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_send(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    bus.fifo_rxf_n_i = 1'b0;
    bus.fifo_data_i  = b;
    for (int k = 0; k < 30; k++) begin
      step();
      if (bus.fifo_rd_n_o == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    step();
    bus.fifo_rxf_n_i = 1'b1;
    repeat (3) step();
  endtask

  task automatic offer_sample(input logic [23:0] l, input logic [23:0] r, output bit ok);
    ok = 1'b0;
    bus.sample_left_i  = l;
    bus.sample_right_i = r;
    bus.sample_valid_i = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (bus.sample_ready_o) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    step();
    bus.sample_valid_i = 1'b0;
  endtask

  task automatic collect_frame(input int hold_after, input int hold_len, input int rxf_at,
                               output logic [47:0] got, output int n, output int first_cyc,
                               output int last_cyc, output int held_low, output int held_changes,
                               output logic [7:0] held_data, output int oe_low);
    int held;
    got = '0; n = 0; first_cyc = -1; last_cyc = -1;
    held = 0; held_low = 0; held_changes = 0; held_data = 8'h00; oe_low = 0;
    for (int k = 0; k < 40 && !(n == 6 && bus.fifo_wr_n_o); k++) begin
      if (n == hold_after && held < hold_len) begin
        bus.fifo_txe_n_i = 1'b1;
        if (held == 0) held_data = bus.fifo_data_o;
        else if (bus.fifo_data_o !== held_data) held_changes++;
        if (!bus.fifo_wr_n_o) held_low++;
        held++;
      end else begin
        bus.fifo_txe_n_i = 1'b0;
      end
      if (rxf_at >= 0 && n >= rxf_at) bus.fifo_rxf_n_i = 1'b0;
      if (!bus.fifo_oe_n_o) oe_low++;
      if (!bus.fifo_wr_n_o && !bus.fifo_txe_n_i && n < 6) begin
        got[n*8 +: 8] = bus.fifo_data_o;
        if (n == 0) first_cyc = k;
        last_cyc = k;
        n++;
      end
      step();
    end
  endtask

  localparam logic [47:0] EXP_FRAME = 48'hABCDEF_123456;

  task automatic test_reset();
    bus.sample_valid_i = 1'b0;
    bus.sample_left_i  = '0;
    bus.sample_right_i = '0;
    bus.fifo_txe_n_i   = 1'b1;
    bus.fifo_rxf_n_i   = 1'b1;
    bus.fifo_data_i    = 8'h00;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) step();
    total_cnt++;
    if ({bus.fifo_oe_n_o, bus.fifo_rd_n_o, bus.fifo_wr_n_o, bus.fifo_siwu_o, bus.fifo_data_oe_o,
         bus.fifo_data_o, bus.ft2232_reset_n_o, bus.streaming_o, bus.rate_sel_o,
         bus.sample_ready_o, bus.led_user_o} !== {4'b1111, 1'b0, 8'h00, 5'b00000})
      $display("FAIL reset_values: oe_n=%b rd_n=%b wr_n=%b siwu=%b doe=%b data=%h ftrst=%b str=%b rate=%b rdy=%b led=%b, want 1111 0 00 00000",
               bus.fifo_oe_n_o, bus.fifo_rd_n_o, bus.fifo_wr_n_o, bus.fifo_siwu_o, bus.fifo_data_oe_o,
               bus.fifo_data_o, bus.ft2232_reset_n_o, bus.streaming_o, bus.rate_sel_o,
               bus.sample_ready_o, bus.led_user_o);
    else pass_cnt++;
    rst_n = 1'b1;
    step();
    total_cnt++;
    if (bus.ft2232_reset_n_o !== 1'b1 || bus.sample_ready_o !== 1'b1)
      $display("FAIL reset_release: ftrst=%b ready=%b, want 1 1", bus.ft2232_reset_n_o, bus.sample_ready_o);
    else pass_cnt++;
  endtask

  task automatic test_cmd_read();
    bit ok;
    bus.fifo_rxf_n_i = 1'b0;
    bus.fifo_data_i  = CMD_RATE_44K;
    step();
    total_cnt++;
    if (bus.fifo_oe_n_o !== 1'b1 || bus.sample_ready_o !== 1'b0)
      $display("FAIL cmd_idle_exit: oe_n=%b ready=%b, want 1 0", bus.fifo_oe_n_o, bus.sample_ready_o);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.fifo_oe_n_o !== 1'b0 || bus.fifo_rd_n_o !== 1'b1 || bus.fifo_data_oe_o !== 1'b0)
      $display("FAIL cmd_rd_oe: oe_n=%b rd_n=%b doe=%b, want 0 1 0", bus.fifo_oe_n_o, bus.fifo_rd_n_o, bus.fifo_data_oe_o);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.fifo_oe_n_o !== 1'b0 || bus.fifo_rd_n_o !== 1'b0)
      $display("FAIL cmd_rd: oe_n=%b rd_n=%b, want 0 0", bus.fifo_oe_n_o, bus.fifo_rd_n_o);
    else pass_cnt++;
    step();
    bus.fifo_rxf_n_i = 1'b1;
    step();
    total_cnt++;
    if (bus.rate_sel_o !== 1'b1 || bus.fifo_oe_n_o !== 1'b1 || bus.fifo_rd_n_o !== 1'b1)
      $display("FAIL cmd_rate44_turn: rate=%b oe_n=%b rd_n=%b, want 1 1 1", bus.rate_sel_o, bus.fifo_oe_n_o, bus.fifo_rd_n_o);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.sample_ready_o !== 1'b1)
      $display("FAIL cmd_back_idle: ready=%b, want 1", bus.sample_ready_o);
    else pass_cnt++;
    host_send(CMD_RATE_48K, ok);
    total_cnt++;
    if (!ok || bus.rate_sel_o !== 1'b0)
      $display("FAIL cmd_rate48: read_seen=%b rate=%b, want 1 0", ok, bus.rate_sel_o);
    else pass_cnt++;
  endtask

  task automatic test_streaming();
    bit ok, ok2;
    logic [47:0] got;
    logic [7:0]  hd;
    int n, f, l, hl, hc, ol;
    host_send(CMD_START, ok);
    total_cnt++;
    if (!ok || bus.streaming_o !== 1'b1 || bus.led_user_o !== 1'b1)
      $display("FAIL stream_start: read_seen=%b streaming=%b led=%b, want 1 1 1", ok, bus.streaming_o, bus.led_user_o);
    else pass_cnt++;
    offer_sample(24'h123456, 24'hABCDEF, ok2);
    collect_frame(-1, 0, -1, got, n, f, l, hl, hc, hd, ol);
    total_cnt++;
    if (!ok2 || n != 6 || got !== EXP_FRAME)
      $display("FAIL stream_bytes: accepted=%b n=%0d got=%h, want 1 6 %h", ok2, n, got, EXP_FRAME);
    else pass_cnt++;
    total_cnt++;
    if (f != 1 || l != 6)
      $display("FAIL stream_timing: first_cycle=%0d last_cycle=%0d, want 1 6", f, l);
    else pass_cnt++;
    total_cnt++;
    if (bus.fifo_wr_n_o !== 1'b1 || bus.fifo_data_oe_o !== 1'b0)
      $display("FAIL stream_end: wr_n=%b doe=%b, want 1 0", bus.fifo_wr_n_o, bus.fifo_data_oe_o);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [47:0] got;
    logic [7:0]  hd;
    int n, f, l, hl, hc, ol;
    offer_sample(24'h123456, 24'hABCDEF, ok);
    collect_frame(2, 5, -1, got, n, f, l, hl, hc, hd, ol);
    total_cnt++;
    if (!ok || n != 6 || got !== EXP_FRAME)
      $display("FAIL bp_bytes: accepted=%b n=%0d got=%h, want 1 6 %h", ok, n, got, EXP_FRAME);
    else pass_cnt++;
    total_cnt++;
    if (hl != 5 || hd !== 8'h12 || hc != 0)
      $display("FAIL bp_hold: wr_low_cycles=%0d held=%h changes=%0d, want 5 12 0", hl, hd, hc);
    else pass_cnt++;
  endtask

  task automatic test_read_mid_frame();
    bit ok, ok2;
    logic [47:0] got;
    logic [7:0]  hd;
    int n, f, l, hl, hc, ol;
    bus.fifo_data_i = CMD_STOP;
    offer_sample(24'h123456, 24'hABCDEF, ok);
    collect_frame(-1, 0, 2, got, n, f, l, hl, hc, hd, ol);
    total_cnt++;
    if (!ok || n != 6 || got !== EXP_FRAME || l - f != 5)
      $display("FAIL midread_frame: accepted=%b n=%0d got=%h span=%0d, want 1 6 %h 5", ok, n, got, l - f, EXP_FRAME);
    else pass_cnt++;
    total_cnt++;
    if (ol != 0)
      $display("FAIL midread_no_oe_in_frame: oe_low_cycles=%0d, want 0", ol);
    else pass_cnt++;
    host_send(CMD_STOP, ok2);
    total_cnt++;
    if (!ok2 || bus.streaming_o !== 1'b0)
      $display("FAIL midread_stop: read_seen=%b streaming=%b, want 1 0", ok2, bus.streaming_o);
    else pass_cnt++;
    total_cnt++;
    if (bus_viol != 0)
      $display("FAIL bus_rule: violations=%0d, want 0", bus_viol);
    else pass_cnt++;
  endtask

  task automatic test_stop_discard();
    bit ok, ok2;
    int wr_low;
    host_send(8'h55, ok);
    total_cnt++;
    if (!ok || bus.streaming_o !== 1'b0 || bus.rate_sel_o !== 1'b0)
      $display("FAIL unknown_cmd: read_seen=%b streaming=%b rate=%b, want 1 0 0", ok, bus.streaming_o, bus.rate_sel_o);
    else pass_cnt++;
    bus.fifo_txe_n_i = 1'b0;
    offer_sample(24'h0F0F0F, 24'hF0F0F0, ok2);
    wr_low = 0;
    for (int k = 0; k < 10; k++) begin
      if (!bus.fifo_wr_n_o || bus.fifo_data_oe_o) wr_low++;
      step();
    end
    total_cnt++;
    if (!ok2 || wr_low != 0 || bus.led_user_o !== 1'b0 || bus.sample_ready_o !== 1'b1)
      $display("FAIL discard: accepted=%b write_cycles=%0d led=%b ready=%b, want 1 0 0 1",
               ok2, wr_low, bus.led_user_o, bus.sample_ready_o);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    bit ok, ok2, ok3;
    int wr_low;
    host_send(CMD_RATE_44K, ok);
    host_send(CMD_START, ok2);
    bus.fifo_txe_n_i = 1'b1;
    offer_sample(24'h123456, 24'hABCDEF, ok3);
    step();
    total_cnt++;
    if (!ok || !ok2 || !ok3 || bus.fifo_wr_n_o !== 1'b0 || bus.rate_sel_o !== 1'b1)
      $display("FAIL areset_setup: reads=%b%b accepted=%b wr_n=%b rate=%b, want 11 1 0 1",
               ok, ok2, ok3, bus.fifo_wr_n_o, bus.rate_sel_o);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.fifo_oe_n_o, bus.fifo_rd_n_o, bus.fifo_wr_n_o, bus.fifo_siwu_o, bus.fifo_data_oe_o,
         bus.fifo_data_o, bus.ft2232_reset_n_o, bus.streaming_o, bus.rate_sel_o,
         bus.sample_ready_o, bus.led_user_o} !== {4'b1111, 1'b0, 8'h00, 5'b00000})
      $display("FAIL areset_values: wr_n=%b doe=%b data=%h ftrst=%b str=%b rate=%b rdy=%b led=%b, want 1 0 00 0 0 0 0 0",
               bus.fifo_wr_n_o, bus.fifo_data_oe_o, bus.fifo_data_o, bus.ft2232_reset_n_o,
               bus.streaming_o, bus.rate_sel_o, bus.sample_ready_o, bus.led_user_o);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total_cnt++;
    if (bus.ft2232_reset_n_o !== 1'b1)
      $display("FAIL areset_release: ftrst=%b, want 1", bus.ft2232_reset_n_o);
    else pass_cnt++;
    bus.fifo_txe_n_i = 1'b0;
    wr_low = 0;
    for (int k = 0; k < 10; k++) begin
      if (!bus.fifo_wr_n_o) wr_low++;
      step();
    end
    total_cnt++;
    if (wr_low != 0)
      $display("FAIL areset_discard: write_cycles=%0d, want 0", wr_low);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_cmd_read();
    test_streaming();
    test_backpressure();
    test_read_mid_frame();
    test_stop_discard();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
